// File: rtl/timer_reg_cnt.sv
// timer_reg_cnt: register bank and 64-bit count engine of the timer IP.
// Sits behind the APB slave FSM: consumes its one-cycle wr_en/rd_en strobes,
// returns zero-wait-state read data and exports the TCR fields back to it.
// Optional build macro: TIMER_HALT_EN adds the dbg_mode input and the THCSR
// register at 0x01C so a debugger can freeze the divider and counter.
module timer_reg_cnt #(
  parameter int ADDR_W  = 12,
  parameter int DIV_MAX = 8
) (
  input  logic              pclk,
  input  logic              prst_n,
`ifdef TIMER_HALT_EN
  input  logic              dbg_mode,
`endif
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              timer_en,
  output logic              div_en,
  output logic [3:0]        div_val,
  output logic              tim_int
);

  // The divider counter is as wide as the largest legal div_val, so the
  // longest period (1 << DIV_MAX) fits exactly.
  localparam int DIV_CNT_W = DIV_MAX;

  localparam logic [ADDR_W-1:0] A_TCR   = ADDR_W'(12'h000);
  localparam logic [ADDR_W-1:0] A_TDR0  = ADDR_W'(12'h004);
  localparam logic [ADDR_W-1:0] A_TDR1  = ADDR_W'(12'h008);
  localparam logic [ADDR_W-1:0] A_TCMP0 = ADDR_W'(12'h00C);
  localparam logic [ADDR_W-1:0] A_TCMP1 = ADDR_W'(12'h010);
  localparam logic [ADDR_W-1:0] A_TIER  = ADDR_W'(12'h014);
  localparam logic [ADDR_W-1:0] A_TISR  = ADDR_W'(12'h018);
`ifdef TIMER_HALT_EN
  localparam logic [ADDR_W-1:0] A_THCSR = ADDR_W'(12'h01C);
`endif

  // Byte-lane merge: lanes with their strobe set take the new data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic                 timer_en_r;
  logic                 div_en_r;
  logic [3:0]           div_val_r;
  logic [DIV_CNT_W-1:0] div_cnt_r;
  logic [63:0]          cnt_r;
  logic [31:0]          tcmp0_r;
  logic [31:0]          tcmp1_r;
  logic                 int_en_r;
  logic                 int_st_r;

  logic        tcr_wr_s, tdr0_wr_s, tdr1_wr_s, tcmp0_wr_s, tcmp1_wr_s;
  logic        tier_wr_s, tisr_wr_s;
  logic        halted_s, active_s, tick_s, en_fall_s, match_s, w1c_s;
  logic [15:0] div_lim_s;
  logic [31:0] rd_data_s;

  assign tcr_wr_s   = wr_en && (paddr == A_TCR);
  assign tdr0_wr_s  = wr_en && (paddr == A_TDR0);
  assign tdr1_wr_s  = wr_en && (paddr == A_TDR1);
  assign tcmp0_wr_s = wr_en && (paddr == A_TCMP0);
  assign tcmp1_wr_s = wr_en && (paddr == A_TCMP1);
  assign tier_wr_s  = wr_en && (paddr == A_TIER);
  assign tisr_wr_s  = wr_en && (paddr == A_TISR);

`ifdef TIMER_HALT_EN
  logic halt_req_r;
  logic thcsr_wr_s;
  assign thcsr_wr_s = wr_en && (paddr == A_THCSR);
  assign halted_s   = dbg_mode && halt_req_r;

  // Debug halt request bit; halt_ack is derived, not stored.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      halt_req_r <= 1'b0;
    end else if (thcsr_wr_s && pstrb[0]) begin
      halt_req_r <= pwdata[0];
    end
  end
`else
  assign halted_s = 1'b0;
`endif

  assign active_s  = timer_en_r && !halted_s;
  assign div_lim_s = (16'd1 << div_val_r) - 16'd1;
  // A TCR write that drops timer_en resets the count on the same edge.
  assign en_fall_s = tcr_wr_s && timer_en_r && pstrb[0] && !pwdata[0];
  // Compare uses the registered count, so it also matches while stopped.
  assign match_s   = (cnt_r == {tcmp1_r, tcmp0_r});
  assign w1c_s     = tisr_wr_s && pstrb[0] && pwdata[0];

  // Count enable: every active cycle, or once per divided period.
  always_comb begin
    tick_s = 1'b0;
    if (active_s) begin
      if (div_en_r) begin
        tick_s = (16'(div_cnt_r) == div_lim_s);
      end else begin
        tick_s = 1'b1;
      end
    end else begin
      tick_s = 1'b0;
    end
  end

  // TCR fields; values are taken as written, legality is checked upstream.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      timer_en_r <= 1'b0;
      div_en_r   <= 1'b0;
      div_val_r  <= 4'd1;
    end else if (tcr_wr_s) begin
      if (pstrb[0]) begin
        timer_en_r <= pwdata[0];
        div_en_r   <= pwdata[1];
      end
      if (pstrb[1]) begin
        div_val_r <= pwdata[11:8];
      end
    end
  end

  // Prescaler: restarts on any TCR write or whenever dividing is off.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      div_cnt_r <= '0;
    end else if (!timer_en_r || !div_en_r || tcr_wr_s) begin
      div_cnt_r <= '0;
    end else if (active_s) begin
      div_cnt_r <= tick_s ? '0 : div_cnt_r + 1'b1;
    end
  end

  // 64-bit counter; software writes take priority over a same-cycle tick.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      cnt_r <= 64'd0;
    end else if (en_fall_s) begin
      cnt_r <= 64'd0;
    end else if (tdr0_wr_s) begin
      cnt_r[31:0] <= merge_bytes(cnt_r[31:0], pwdata, pstrb);
    end else if (tdr1_wr_s) begin
      cnt_r[63:32] <= merge_bytes(cnt_r[63:32], pwdata, pstrb);
    end else if (tick_s) begin
      cnt_r <= cnt_r + 64'd1;
    end
  end

  // Compare value and interrupt enable registers.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      tcmp0_r  <= 32'hFFFF_FFFF;
      tcmp1_r  <= 32'hFFFF_FFFF;
      int_en_r <= 1'b0;
    end else begin
      if (tcmp0_wr_s) tcmp0_r <= merge_bytes(tcmp0_r, pwdata, pstrb);
      if (tcmp1_wr_s) tcmp1_r <= merge_bytes(tcmp1_r, pwdata, pstrb);
      if (tier_wr_s && pstrb[0]) int_en_r <= pwdata[0];
    end
  end

  // Sticky status; a match in the clearing cycle keeps it set.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      int_st_r <= 1'b0;
    end else if (match_s) begin
      int_st_r <= 1'b1;
    end else if (w1c_s) begin
      int_st_r <= 1'b0;
    end
  end

  // Zero-wait-state read mux, driven only during a read strobe.
  always_comb begin
    rd_data_s = 32'd0;
    case (paddr)
      A_TCR:   rd_data_s = {20'd0, div_val_r, 6'd0, div_en_r, timer_en_r};
      A_TDR0:  rd_data_s = cnt_r[31:0];
      A_TDR1:  rd_data_s = cnt_r[63:32];
      A_TCMP0: rd_data_s = tcmp0_r;
      A_TCMP1: rd_data_s = tcmp1_r;
      A_TIER:  rd_data_s = {31'd0, int_en_r};
      A_TISR:  rd_data_s = {31'd0, int_st_r};
`ifdef TIMER_HALT_EN
      A_THCSR: rd_data_s = {30'd0, halted_s, halt_req_r};
`endif
      default: rd_data_s = 32'd0;
    endcase
    if (rd_en) begin
      prdata = rd_data_s;
    end else begin
      prdata = 32'd0;
    end
  end

  assign timer_en = timer_en_r;
  assign div_en   = div_en_r;
  assign div_val  = div_val_r;
  assign tim_int  = int_st_r && int_en_r;

endmodule

// File: tb/tb_timer_reg_cnt.sv
// tb_timer_reg_cnt: directed bench for timer_reg_cnt with a register-image
// reference model compared against the outputs on every falling edge.
// Build with +define+TIMER_HALT_EN to also exercise the debug halt.
module tb_timer_reg_cnt;

  logic        pclk = 1'b0;
  logic        prst_n;
  logic        wr_en, rd_en;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb, div_val;
  logic        timer_en, div_en, tim_int;
`ifdef TIMER_HALT_EN
  logic        dbg_mode;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  logic [11:0] idle_addr = 12'h004;

  // Reference model state: software-visible register images.
  logic        m_en, m_den, m_ie, m_is, m_hreq;
  logic [3:0]  m_dval;
  logic [63:0] m_cnt, m_cmp;
  longint unsigned m_phase;

  timer_reg_cnt dut (
    .pclk     (pclk),
    .prst_n   (prst_n),
`ifdef TIMER_HALT_EN
    .dbg_mode (dbg_mode),
`endif
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .tim_int  (tim_int)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic model_halted();
`ifdef TIMER_HALT_EN
    return dbg_mode && m_hreq;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_den = 1'b0; m_dval = 4'd1; m_cnt = 64'd0;
    m_cmp = {64{1'b1}}; m_ie = 1'b0; m_is = 1'b0; m_hreq = 1'b0; m_phase = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h000: return {20'd0, m_dval, 6'd0, m_den, m_en};
      12'h004: return m_cnt[31:0];
      12'h008: return m_cnt[63:32];
      12'h00C: return m_cmp[31:0];
      12'h010: return m_cmp[63:32];
      12'h014: return {31'd0, m_ie};
      12'h018: return {31'd0, m_is};
`ifdef TIMER_HALT_EN
      12'h01C: return {30'd0, model_halted(), m_hreq};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the reference model, using the inputs of that cycle.
  task automatic model_step();
    logic [31:0] mk, tcr_old, tcr_new;
    longint unsigned period;
    bit active, tick, match, wtcr;
    mk      = bmask(pstrb);
    active  = m_en && !model_halted();
    period  = m_den ? (64'd1 << m_dval) : 64'd1;
    tick    = active && (((m_phase + 1) % period) == 0);
    match   = (m_cnt == m_cmp);
    wtcr    = wr_en && (paddr == 12'h000);
    tcr_old = {20'd0, m_dval, 6'd0, m_den, m_en};
    tcr_new = (tcr_old & ~mk) | (pwdata & mk);
    // active cycles since the prescaler was last restarted
    if (!m_en || !m_den || wtcr) m_phase = 0;
    else if (active) m_phase = m_phase + 1;
    if (wtcr && m_en && !tcr_new[0]) m_cnt = 64'd0;
    else if (wr_en && paddr == 12'h004) m_cnt[31:0] = (m_cnt[31:0] & ~mk) | (pwdata & mk);
    else if (wr_en && paddr == 12'h008) m_cnt[63:32] = (m_cnt[63:32] & ~mk) | (pwdata & mk);
    else if (tick) m_cnt = m_cnt + 64'd1;
    if (match) m_is = 1'b1;
    else if (wr_en && paddr == 12'h018 && pstrb[0] && pwdata[0]) m_is = 1'b0;
    if (wtcr) begin
      m_en = tcr_new[0]; m_den = tcr_new[1]; m_dval = tcr_new[11:8];
    end
    if (wr_en && paddr == 12'h00C) m_cmp[31:0]  = (m_cmp[31:0]  & ~mk) | (pwdata & mk);
    if (wr_en && paddr == 12'h010) m_cmp[63:32] = (m_cmp[63:32] & ~mk) | (pwdata & mk);
    if (wr_en && paddr == 12'h014 && pstrb[0]) m_ie = pwdata[0];
    if (wr_en && paddr == 12'h01C && pstrb[0]) m_hreq = pwdata[0];
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge pclk) begin
    if (chk_on) begin
      check("prdata",   {32'd0, prdata},   {32'd0, (rd_en ? model_read(paddr) : 32'd0)});
      check("timer_en", {63'd0, timer_en}, {63'd0, m_en});
      check("div_en",   {63'd0, div_en},   {63'd0, m_den});
      check("div_val",  {60'd0, div_val},  {60'd0, m_dval});
      check("tim_int",  {63'd0, tim_int},  {63'd0, (m_is && m_ie)});
    end
  end

  task automatic cyc();
    @(posedge pclk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    paddr = a; pwdata = d; pstrb = s; wr_en = 1'b1; rd_en = 1'b0;
    cyc();
    wr_en = 1'b0; pstrb = 4'd0; rd_en = 1'b1; paddr = idle_addr;
  endtask

  task automatic rd_lit(input string name, input logic [11:0] a, input logic [31:0] exp);
    paddr = a; rd_en = 1'b1;
    #1;
    check(name, {32'd0, prdata}, {32'd0, exp});
    paddr = idle_addr;
  endtask

  initial begin
    prst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b1; paddr = idle_addr;
    pwdata = 32'd0; pstrb = 4'd0;
`ifdef TIMER_HALT_EN
    dbg_mode = 1'b0;
`endif
    model_reset();
    chk_on = 1'b1;
    repeat (2) @(posedge pclk);
    #1 prst_n = 1'b1;

    // reset values
    rd_lit("t1_tcr_reset", 12'h000, 32'h0000_0100);
    rd_lit("t1_tcmp0_reset", 12'h00C, 32'hFFFF_FFFF);
    check("t1_div_val", {60'd0, div_val}, 64'd1);

    // divide by 8: ten ticks in 80 cycles
    wr(12'h000, 32'h0000_0303, 4'hF);
    repeat (80) cyc();
    paddr = 12'h004; #1;
    n_chk++;
    if (prdata < 32'd9 || prdata > 32'd11) begin
      n_fail++;
      $display("FAIL t2_div8: got %0d expected 10 +-1", prdata);
    end
    paddr = idle_addr;

    // byte strobes and unmapped address
    wr(12'h00C, 32'hAABB_CCDD, 4'b0101);
    rd_lit("t3_strobe", 12'h00C, 32'hFFBB_FFDD);
    wr(12'h020, 32'hFFFF_FFFF, 4'hF);
    rd_lit("t3_unmapped", 12'h020, 32'h0000_0000);

    // wrap and write-over-tick
    wr(12'h000, 32'h0, 4'hF);
    wr(12'h004, 32'hFFFF_FFFF, 4'hF);
    wr(12'h008, 32'hFFFF_FFFF, 4'hF);
    wr(12'h000, 32'h1, 4'hF);
    rd_lit("t4_pre_wrap", 12'h008, 32'hFFFF_FFFF);
    cyc();
    rd_lit("t4_wrap_lo", 12'h004, 32'h0);
    rd_lit("t4_wrap_hi", 12'h008, 32'h0);
    wr(12'h008, 32'h1234_5678, 4'hF);
    rd_lit("t4_wr_hi", 12'h008, 32'h1234_5678);
    rd_lit("t4_no_inc", 12'h004, 32'h0);

    // interrupt on compare, W1C versus set
    wr(12'h000, 32'h0, 4'hF);
    wr(12'h00C, 32'h5, 4'hF);
    wr(12'h010, 32'h0, 4'hF);
    wr(12'h014, 32'h1, 4'hF);
    wr(12'h018, 32'h1, 4'hF);
    wr(12'h000, 32'h1, 4'hF);
    repeat (5) cyc();
    check("t5_before", {63'd0, tim_int}, 64'd0);
    cyc();
    check("t5_rise", {63'd0, tim_int}, 64'd1);
    wr(12'h000, 32'h0, 4'hF);
    wr(12'h00C, 32'h0, 4'hF);
    wr(12'h018, 32'h1, 4'h1);
    check("t5_set_wins", {63'd0, tim_int}, 64'd1);
    rd_lit("t5_tisr", 12'h018, 32'h1);
    wr(12'h00C, 32'h5, 4'hF);
    wr(12'h018, 32'h1, 4'h1);
    check("t5_cleared", {63'd0, tim_int}, 64'd0);

`ifdef TIMER_HALT_EN
    // debug halt freezes the count
    wr(12'h000, 32'h1, 4'hF);
    repeat (3) cyc();
    wr(12'h01C, 32'h1, 4'hF);
    dbg_mode = 1'b1;
    repeat (5) cyc();
    rd_lit("t6_thcsr", 12'h01C, 32'h3);
    rd_lit("t6_frozen", 12'h004, 32'h4);
    dbg_mode = 1'b0;
    repeat (3) cyc();
    rd_lit("t6_resume", 12'h004, 32'h7);
    rd_lit("t6_ack_low", 12'h01C, 32'h1);
`endif

    // asynchronous reset while counting
    wr(12'h000, 32'h1, 4'hF);
    repeat (4) cyc();
    prst_n = 1'b0;
    model_reset();
    #1;
    check("t1_mid_en", {63'd0, timer_en}, 64'd0);
    check("t1_mid_div_val", {60'd0, div_val}, 64'd1);
    check("t1_mid_int", {63'd0, tim_int}, 64'd0);
    rd_lit("t1_mid_tcr", 12'h000, 32'h0000_0100);
    rd_en = 1'b0; #1;
    check("t1_mid_prdata", {32'd0, prdata}, 64'd0);
    rd_en = 1'b1;
    repeat (2) @(posedge pclk);
    #1 prst_n = 1'b1;
    repeat (3) cyc();
    rd_lit("t1_no_restart", 12'h004, 32'h0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
